solve_sequencer: RTL and testbench
==================================

// Module: solve_sequencer
// PURPOSE
//  Sequences one field-solve pass per timestep, downstream of the step controller.
//  - On start_solve, issues one grid-cell read per cell, in raster order, to the field-solver pipeline.
//  - Counts the results the pipeline returns.
//  - Pulses solve_done when every cell has been returned.
//  - Keeps the timestep counter that drives the controller's last_step input.
// PARAMETERS
//  GRID_X     64    cells per row (power of 2, >=2)
//  GRID_Y     64    rows (power of 2, >=2)
//  NUM_STEPS  1024  timesteps per run; last_step asserts on the final one
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  async active-high reset
//  start_solve  in   1                  level from controller; high until after solve_done
//  step_clr     in   1                  sync clear of step counter (new run from UI)
//  rd_ready     in   1                  solver pipeline accepts a cell address
//  res_valid    in   1                  solver pipeline returns one cell result
//  rd_valid     out  1                  cell address valid
//  rd_x         out  $clog2(GRID_X)     cell column
//  rd_y         out  $clog2(GRID_Y)     cell row
//  solve_done   out  1                  1-cycle pulse: pass complete
//  last_step    out  1                  step_cnt == NUM_STEPS-1
//  busy         out  1                  state != IDLE
//  err          out  1                  sticky: unexpected res_valid
// BEHAVIOUR
//  Reset (async, any time, including mid-pass):
//   - state=IDLE, armed=1.
//   - rd_x, rd_y, ret_cnt, step_cnt = 0.
//   - All outputs 0, except last_step, which follows the step_cnt decode (0 unless NUM_STEPS==1).
//   - In-flight results are discarded.
//  Width rules: ret_cnt is $clog2(GRID_X*GRID_Y+1) bits; step_cnt is $clog2(NUM_STEPS) bits.
//  armed:
//   - Cleared on entry to DONE.
//   - Set on any cycle with start_solve==0.
//   - Effect: a held-high start_solve never starts a second pass.
//  IDLE:
//   - If start_solve && armed: go to ISSUE next cycle and clear rd_x, rd_y, ret_cnt.
//  ISSUE:
//   - rd_valid=1.
//   - Beat = rd_valid && rd_ready. On each beat, rd_x increments; on wrap, rd_y increments.
//   - rd_x and rd_y are held stable while rd_ready==0.
//   - Beat at (GRID_X-1, GRID_Y-1): rd_valid drops next cycle; go to DRAIN.
//  ret_cnt:
//   - Increments on res_valid in ISSUE or DRAIN.
//   - Results may return during ISSUE.
//   - res_valid in IDLE/DONE, or with ret_cnt==GRID_X*GRID_Y, sets err and does not count.
//  DRAIN:
//   - When ret_cnt==GRID_X*GRID_Y, go to DONE.
//   - If the final result arrives on the last-beat cycle, the FSM still passes through DRAIN for 1 cycle.
//  DONE:
//   - solve_done=1 for exactly 1 cycle.
//   - step_cnt increments, wrapping at NUM_STEPS-1 -> 0.
//   - Go to IDLE.
//  step_clr:
//   - Zeroes step_cnt and overrides the DONE increment in the same cycle.
//   - Does not affect the FSM.
//  Minimum pass latency (rd_ready always 1, 1-cycle return):
//   - GRID_X*GRID_Y+2 cycles from start_solve sampled to solve_done.
//  rd_ready==0 indefinitely: the sequencer stalls in ISSUE with no timeout.
// CONFIGURATION
//  SOLVE_PERF_EN defined:
//   - Adds output perf_cycles, 32 bits, reset 0.
//   - A free counter clears on ISSUE entry and increments every non-IDLE cycle.
//   - The count is latched into perf_cycles on the DONE cycle and saturates at 2^32-1.
//  SOLVE_PERF_EN undefined:
//   - perf_cycles port and counter are absent.
//   - All other behaviour is identical.
// TESTING
//  1. GRID 4x4, rd_ready=1, 1-cycle return:
//     - 16 beats, addresses (0,0)..(3,3) in x-fastest order.
//     - solve_done at cycle 18 after start; step_cnt=1.
//  2. rd_ready toggling 1/0:
//     - Addresses hold while stalled; exactly 16 beats.
//     - solve_done only after 16th res_valid.
//  3. start_solve held high 5 cycles past solve_done:
//     - No second pass; busy=0.
//     - Next pass only after start_solve low then high.
//  4. NUM_STEPS=3, 3 passes:
//     - last_step=1 after 2nd solve_done.
//     - 0 after 3rd (wrap); step_clr mid-run forces step_cnt=0.
//  5. Async rst asserted mid-ISSUE at beat 7:
//     - Immediately rd_valid=0, busy=0, err=0.
//     - Fresh start gives full 16-beat pass.
//  6. Extra res_valid in IDLE:
//     - err=1 sticky, ret_cnt unchanged.
//     - With SOLVE_PERF_EN, test 1 gives perf_cycles=18.

Source files
------------

// File: rtl/solve_sequencer.sv
// Field-solve pass sequencer: raster cell reads, result counting, timestep counter.
// Define SOLVE_PERF_EN to add the perf_cycles pass-length counter output.
module solve_sequencer #(
    parameter int GRID_X    = 64,
    parameter int GRID_Y    = 64,
    parameter int NUM_STEPS = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_solve,
    input  logic                      step_clr,
    input  logic                      rd_ready,
    input  logic                      res_valid,
    output logic                      rd_valid,
    output logic [$clog2(GRID_X)-1:0] rd_x,
    output logic [$clog2(GRID_Y)-1:0] rd_y,
    output logic                      solve_done,
    output logic                      last_step,
    output logic                      busy,
    output logic                      err
`ifdef SOLVE_PERF_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam int XW    = $clog2(GRID_X);
    localparam int YW    = $clog2(GRID_Y);
    localparam int NCELL = GRID_X * GRID_Y;
    localparam int CW    = $clog2(NCELL + 1);
    localparam int SW    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   rd_x_q, rd_x_d;
    logic [YW-1:0]   rd_y_q, rd_y_d;
    logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic            armed_q, armed_d;
    logic            err_q, err_d;
    logic            beat, last_beat, full, res_bad;

    always_comb begin
        beat       = (state_q == ISSUE) && rd_ready;
        last_beat  = beat && (rd_x_q == XW'(GRID_X - 1))
                          && (rd_y_q == YW'(GRID_Y - 1));
        full       = (ret_cnt_q == CW'(NCELL));
        // Results outside a pass, or beyond the grid size, are protocol errors.
        res_bad    = res_valid && ((state_q == IDLE) || (state_q == DONE) || full);
        state_d    = state_q;
        rd_x_d     = rd_x_q;
        rd_y_d     = rd_y_q;
        step_cnt_d = step_cnt_q;
        err_d      = err_q | res_bad;
        ret_cnt_d  = (res_valid && !res_bad) ? ret_cnt_q + CW'(1) : ret_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_solve && armed_q) begin
                    state_d   = ISSUE;
                    rd_x_d    = '0;
                    rd_y_d    = '0;
                    ret_cnt_d = '0;
                end
            end
            ISSUE: begin
                if (beat) begin
                    rd_x_d = rd_x_q + XW'(1);
                    if (rd_x_q == XW'(GRID_X - 1))
                        rd_y_d = rd_y_q + YW'(1);
                end
                if (last_beat)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (full)
                    state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                step_cnt_d = (step_cnt_q == SW'(NUM_STEPS - 1)) ? '0
                                                                : step_cnt_q + SW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (step_clr)
            step_cnt_d = '0;

        // Re-arm only once start_solve drops, so a held level runs one pass.
        if (!start_solve)
            armed_d = 1'b1;
        else if ((state_d == DONE) && (state_q != DONE))
            armed_d = 1'b0;
        else
            armed_d = armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            ret_cnt_q  <= '0;
            step_cnt_q <= '0;
            armed_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            ret_cnt_q  <= ret_cnt_d;
            step_cnt_q <= step_cnt_d;
            armed_q    <= armed_d;
            err_q      <= err_d;
        end
    end

    assign rd_valid   = (state_q == ISSUE);
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign solve_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign last_step  = (step_cnt_q == SW'(NUM_STEPS - 1));

`ifdef SOLVE_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if ((state_q == IDLE) && (state_d == ISSUE))
            perf_cnt_d = '0;
        else if ((state_q != IDLE) && (perf_cnt_q != '1))
            perf_cnt_d = perf_cnt_q + 32'd1;
        perf_d = (state_q == DONE) ? perf_cnt_q : perf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_solve_sequencer.sv
// Bench for solve_sequencer on a 4x4 grid with 3 timesteps per run.
// Randomized ready/return traffic checked against a raster-order model.
module tb_solve_sequencer;

    localparam int GX = 4;
    localparam int GY = 4;
    localparam int NS = 3;
    localparam int NC = GX * GY;

    logic       clk = 1'b0;
    logic       rst, start_solve, step_clr, rd_ready, res_valid;
    logic       rd_valid, solve_done, last_step, busy, err;
    logic [1:0] rd_x, rd_y;
`ifdef SOLVE_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int model_step = 0;

    always #5 clk = ~clk;

    solve_sequencer #(.GRID_X(GX), .GRID_Y(GY), .NUM_STEPS(NS)) dut (
        .clk(clk), .rst(rst), .start_solve(start_solve), .step_clr(step_clr),
        .rd_ready(rd_ready), .res_valid(res_valid), .rd_valid(rd_valid),
        .rd_x(rd_x), .rd_y(rd_y), .solve_done(solve_done),
        .last_step(last_step), .busy(busy), .err(err)
`ifdef SOLVE_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1-cycle return; 1: ready toggles; 2: random ready.
    task automatic drive_pass(input int mode, input int abort_at, input bit clr_at_done,
                              output int beats, output int lat, output int addr_err,
                              output int hold_err, output int early, output int tmo);
        int cyc, got, pend;
        bit prev_beat, pstall, b;
        logic [1:0] px, py;
        beats = 0; lat = 0; addr_err = 0; hold_err = 0; early = 0; tmo = 0;
        cyc = 0; got = 0; pend = 0; prev_beat = 0; pstall = 0; px = 0; py = 0;
        res_valid = 0; rd_ready = 0; step_clr = 0; start_solve = 0;
        tick;
        start_solve = 1;
        tick;
        while (solve_done !== 1'b1 && cyc < 2000) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = (cyc % 2 == 0);
                default: rd_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (mode == 0) res_valid = prev_beat;
            else res_valid = (pend > 0) && ($urandom_range(0, 1) == 1);
            if (res_valid) begin got++; pend--; end
            b = (rd_valid === 1'b1) && rd_ready;
            if (pstall && (rd_x !== px || rd_y !== py)) hold_err++;
            if (b) begin
                if (rd_x !== 2'(beats % GX) || rd_y !== 2'(beats / GX)) addr_err++;
                beats++;
                pend++;
            end
            prev_beat = b;
            pstall = (rd_valid === 1'b1) && !rd_ready;
            px = rd_x; py = rd_y;
            tick;
            cyc++;
            if (abort_at > 0 && beats == abort_at) break;
        end
        lat = cyc;
        tmo = (cyc >= 2000) ? 1 : 0;
        if (solve_done === 1'b1 && got < NC) early = 1;
        res_valid = 0; rd_ready = 0;
        if (abort_at == 0) begin
            step_clr = clr_at_done;
            tick;
            step_clr = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1; start_solve = 0; step_clr = 0; rd_ready = 0; res_valid = 0;
        #12;
        rst = 0;
        tick;
        n_checks++; if ({rd_valid, busy, err, solve_done} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b exp 0000", {rd_valid, busy, err, solve_done}); end
        n_checks++; if ({rd_x, rd_y} !== 4'b0) begin n_fail++;
            $display("FAIL reset_addr: got %h exp 0", {rd_x, rd_y}); end
        n_checks++; if (last_step !== 1'b0) begin n_fail++;
            $display("FAIL reset_last_step: got %b exp 0", last_step); end
`ifdef SOLVE_PERF_EN
        n_checks++; if (perf_cycles !== 32'd0) begin n_fail++;
            $display("FAIL reset_perf: got %0d exp 0", perf_cycles); end
`endif
    endtask

    task automatic test_basic;
        int beats, lat, ae, he, early, tmo;
        drive_pass(0, 0, 0, beats, lat, ae, he, early, tmo);
        model_step = (model_step + 1) % NS;
        n_checks++; if (beats !== NC) begin n_fail++;
            $display("FAIL basic_beats: got %0d exp %0d", beats, NC); end
        n_checks++; if (ae !== 0) begin n_fail++;
            $display("FAIL basic_order: got %0d bad addrs exp 0", ae); end
        n_checks++; if (lat !== NC + 2) begin n_fail++;
            $display("FAIL basic_latency: got %0d exp %0d", lat, NC + 2); end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL basic_busy: got %b exp 0", busy); end
        n_checks++; if (last_step !== (model_step == NS - 1)) begin n_fail++;
            $display("FAIL basic_last_step: got %b step %0d", last_step, model_step); end
`ifdef SOLVE_PERF_EN
        n_checks++; if (perf_cycles !== 32'(NC + 2)) begin n_fail++;
            $display("FAIL basic_perf: got %0d exp %0d", perf_cycles, NC + 2); end
`endif
    endtask

    task automatic test_stall(input int mode, input string nm);
        int beats, lat, ae, he, early, tmo;
        drive_pass(mode, 0, 0, beats, lat, ae, he, early, tmo);
        model_step = (model_step + 1) % NS;
        n_checks++; if (tmo !== 0) begin n_fail++;
            $display("FAIL %s_timeout: got %0d cycles", nm, lat); end
        n_checks++; if (beats !== NC) begin n_fail++;
            $display("FAIL %s_beats: got %0d exp %0d", nm, beats, NC); end
        n_checks++; if (ae !== 0 || he !== 0) begin n_fail++;
            $display("FAIL %s_addr: got order %0d hold %0d exp 0 0", nm, ae, he); end
        n_checks++; if (early !== 0) begin n_fail++;
            $display("FAIL %s_early_done: got %0d exp 0", nm, early); end
        n_checks++; if (last_step !== (model_step == NS - 1)) begin n_fail++;
            $display("FAIL %s_last_step: got %b step %0d", nm, last_step, model_step); end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++; if ({busy, rd_valid} !== 2'b00) begin n_fail++;
                $display("FAIL hold_no_repass: cycle %0d got busy/rd_valid %b exp 00",
                         i, {busy, rd_valid}); end
        end
        test_stall(2, "hold_rand");
    endtask

    task automatic test_step_clr;
        int beats, lat, ae, he, early, tmo;
        for (int p = 0; p < 5; p++) begin
            drive_pass(0, 0, (p == 2), beats, lat, ae, he, early, tmo);
            model_step = (p == 2) ? 0 : (model_step + 1) % NS;
            n_checks++; if (last_step !== (model_step == NS - 1)) begin n_fail++;
                $display("FAIL clr_pass%0d_last_step: got %b step %0d",
                         p, last_step, model_step); end
        end
        step_clr = 1;
        tick;
        step_clr = 0;
        model_step = 0;
        n_checks++; if (last_step !== 1'b0) begin n_fail++;
            $display("FAIL clr_idle_last_step: got %b exp 0", last_step); end
    endtask

    task automatic test_err;
        int beats, lat, ae, he, early, tmo;
        n_checks++; if (err !== 1'b0) begin n_fail++;
            $display("FAIL err_clean: got %b exp 0", err); end
        res_valid = 1;
        tick;
        res_valid = 0;
        n_checks++; if (err !== 1'b1) begin n_fail++;
            $display("FAIL err_idle_res: got %b exp 1", err); end
        drive_pass(0, 0, 0, beats, lat, ae, he, early, tmo);
        model_step = (model_step + 1) % NS;
        n_checks++; if (beats !== NC || lat !== NC + 2) begin n_fail++;
            $display("FAIL err_pass: got beats %0d lat %0d exp %0d %0d",
                     beats, lat, NC, NC + 2); end
        n_checks++; if (err !== 1'b1) begin n_fail++;
            $display("FAIL err_sticky: got %b exp 1", err); end
    endtask

    task automatic test_reset_mid;
        int beats, lat, ae, he, early, tmo;
        drive_pass(0, 7, 0, beats, lat, ae, he, early, tmo);
        #2 rst = 1;
        #1;
        n_checks++; if ({rd_valid, busy, err, solve_done} !== 4'b0) begin n_fail++;
            $display("FAIL rstmid_flags: got %b exp 0000", {rd_valid, busy, err, solve_done}); end
        n_checks++; if ({rd_x, rd_y} !== 4'b0 || last_step !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_regs: got addr %h last %b exp 0 0",
                     {rd_x, rd_y}, last_step); end
        tick;
        rst = 0;
        tick;
        model_step = 0;
        drive_pass(0, 0, 0, beats, lat, ae, he, early, tmo);
        model_step = (model_step + 1) % NS;
        n_checks++; if (beats !== NC || ae !== 0 || lat !== NC + 2) begin n_fail++;
            $display("FAIL rstmid_fresh: got beats %0d order %0d lat %0d exp %0d 0 %0d",
                     beats, ae, lat, NC, NC + 2); end
        n_checks++; if (err !== 1'b0 || last_step !== (model_step == NS - 1)) begin
            n_fail++;
            $display("FAIL rstmid_status: got err %b last %b step %0d",
                     err, last_step, model_step); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall(1, "stall");
        test_hold();
        test_step_clr();
        test_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
